// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
//   Two-core memory bus controller and snoop sequencer. It arbitrates the two
//   dcaches and two icaches onto the single RAM port. On a dcache miss it
//   snoops the peer dcache. When the peer holds the line dirty, the line is
//   forwarded cache-to-cache and written back to RAM at the same time.
//   Lines are 2 words (8 bytes).
//
// Ports
//   CLK, RST             clock; asynchronous active-high reset
//   dREN, dWEN           per-core dcache read / write requests
//   daddr0/1, dstore0/1  dcache word addresses and write data
//   cctrans, ccwrite     coherence transaction / write-intent-or-dirty flags
//   iREN, iaddr0/1       per-core icache read requests and addresses
//   dwait, iwait         per-requester stall (1 = wait)
//   dload, iload         returned word, shared by both cores
//   ccwait, ccinv        snoop request / invalidate request to snooped core
//   ccsnoopaddr0/1       snoop address presented to each core
//   ramREN, ramWEN       RAM strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and state (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR)
module coherence_bus_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [31:0] daddr0,
  input  logic [31:0] daddr1,
  input  logic [31:0] dstore0,
  input  logic [31:0] dstore1,
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  input  logic [1:0]  iREN,
  input  logic [31:0] iaddr0,
  input  logic [31:0] iaddr1,
  output logic [1:0]  dwait,
  output logic [1:0]  iwait,
  output logic [31:0] dload,
  output logic [31:0] iload,
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [31:0] ccsnoopaddr0,
  output logic [31:0] ccsnoopaddr1,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, SNOOP, C2C0, C2C1, RD0, RD1, IFETCH
  } state_t;

  state_t      state;
  logic        g;          // granted core
  logic        rr;         // round-robin tie-break: core favoured when both request
  logic [31:0] line_addr;  // line base of the current miss

  logic        peer;
  logic        ram_ready;
  logic [1:0]  wb_req, miss_req;
  logic        wb_g, miss_g, if_g;
  logic [31:0] miss_addr;
  logic        start_miss;
  logic [31:0] daddr_g, dstore_g, dstore_peer, iaddr_g;
  logic [31:0] word_off;

  // Tie-break between the two cores of one request class.
  function automatic logic pick(input logic [1:0] req, input logic pri);
    if (req == 2'b11) return pri;
    return req[1];
  endfunction

  assign peer      = ~g;
  // BUSY and ERROR both count as not-ready; the same word is simply retried.
  assign ram_ready = (ramstate == 2'b10);

  // A writeback is dWEN without cctrans; dWEN with cctrans is snoop-response data.
  assign wb_req   = dWEN & ~cctrans;
  assign miss_req = dREN & cctrans;
  assign wb_g     = pick(wb_req, rr);
  assign miss_g   = pick(miss_req, rr);
  assign if_g     = pick(iREN, rr);
  assign miss_addr  = miss_g ? daddr1 : daddr0;
  assign start_miss = (state == IDLE) && (wb_req == 2'b00) && (miss_req != 2'b00);

  assign daddr_g     = g ? daddr1  : daddr0;
  assign dstore_g    = g ? dstore1 : dstore0;
  assign dstore_peer = g ? dstore0 : dstore1;
  assign iaddr_g     = g ? iaddr1  : iaddr0;
  assign word_off    = (state == C2C1 || state == RD1) ? 32'h4 : 32'h0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      g     <= 1'b0;
      rr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req != 2'b00) begin
            g     <= wb_g;
            state <= WB0;
          end else if (miss_req != 2'b00) begin
            g     <= miss_g;
            state <= SNOOP;
          end else if (iREN != 2'b00) begin
            g     <= if_g;
            state <= IFETCH;
          end
        end
        WB0:    if (ram_ready) state <= WB1;
        WB1:    if (ram_ready) begin state <= IDLE; rr <= ~g; end
        SNOOP:  if (cctrans[peer]) state <= ccwrite[peer] ? C2C0 : RD0;
        C2C0:   if (ram_ready) state <= C2C1;
        C2C1:   if (ram_ready) begin state <= IDLE; rr <= ~g; end
        RD0:    if (ram_ready) state <= RD1;
        RD1:    if (ram_ready) begin state <= IDLE; rr <= ~g; end
        IFETCH: if (ram_ready) begin state <= IDLE; rr <= ~g; end
        default: state <= IDLE;
      endcase
    end
  end

  // Miss line base; only meaningful while a miss is in flight.
  always_ff @(posedge CLK) begin
    if (start_miss) line_addr <= miss_addr & ~32'h7;
  end

  always_comb begin
    dwait        = 2'b11;
    iwait        = 2'b11;
    dload        = 32'h0;
    iload        = 32'h0;
    ccwait       = 2'b00;
    ccinv        = 2'b00;
    ccsnoopaddr0 = 32'h0;
    ccsnoopaddr1 = 32'h0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'h0;
    ramstore     = 32'h0;
    case (state)
      WB0, WB1: begin
        ramWEN   = dWEN[g];
        ramaddr  = daddr_g;
        ramstore = dstore_g;
        if (ram_ready) dwait[g] = 1'b0;
      end
      SNOOP: begin
        ccwait[peer] = 1'b1;
        ccinv[peer]  = ccwrite[g];
        if (peer) ccsnoopaddr1 = line_addr;
        else      ccsnoopaddr0 = line_addr;
      end
      C2C0, C2C1: begin
        // Dirty peer data goes to RAM and to the requester in the same beat.
        ccwait[peer] = 1'b1;
        if (peer) ccsnoopaddr1 = line_addr;
        else      ccsnoopaddr0 = line_addr;
        ramWEN   = 1'b1;
        ramaddr  = line_addr | word_off;
        ramstore = dstore_peer;
        dload    = dstore_peer;
        if (ram_ready) dwait = 2'b00;
      end
      RD0, RD1: begin
        ramREN  = 1'b1;
        ramaddr = line_addr | word_off;
        dload   = ramload;
        if (ram_ready) dwait[g] = 1'b0;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_g;
        iload   = ramload;
        if (ram_ready) iwait[g] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Two-core memory bus controller and snoop sequencer. It arbitrates four requesters (dcache0, dcache1, icache0, icache1) onto the single RAM port. For dcache misses it snoops the peer dcache through the cc* handshake. It forwards dirty peer data cache-to-cache while writing the same data back to RAM. It sits between the per-core dcache control FSMs / icaches and the shared RAM.

## Interface
- No parameters. Line size is fixed: 2 words. Core count is fixed: 2.
- Clock and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- dREN  in  2  per-core dcache read request
- dWEN  in  2  per-core dcache write request (writeback or snoop-response data)
- daddr0, daddr1  in  32  dcache word addresses
- dstore0, dstore1  in  32  dcache write data
- cctrans  in  2  dcache coherence transaction: with dREN, a miss; during snoop, response valid
- ccwrite  in  2  requester: miss is write-intent; snooper: has dirty line
- iREN  in  2  per-core icache read request
- iaddr0, iaddr1  in  32  icache addresses
- dwait, iwait  out  2 each  wait (1 = stall), per requester
- dload, iload  out  32 each  returned word, shared (valid only where the matching wait is 0)
- ccwait  out  2  snoop request to core
- ccinv  out  2  invalidate request to snooped core
- ccsnoopaddr0, ccsnoopaddr1  out  32  snoop address
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR

## Operation
- States: IDLE, WB0, WB1, SNOOP, C2C0, C2C1, RD0, RD1, IFETCH.
- Registered: state, granted core g, round-robin bit rr, and a latched miss address.
- IDLE: priorities are (1) dWEN without cctrans (writeback), (2) dREN&cctrans (miss), (3) iREN.
  - Within a class, rr picks when both cores request. rr toggles to !g at every transaction end.
- WB0/WB1: pass dWEN/daddr[g]/dstore[g] to the RAM.
  - dwait[g]=0 in the cycle ramstate==ACCESS; advance.
  - WB1 returns to IDLE.
- SNOOP: latch {daddr[g][31:3],3'b000}.
  - Drive ccwait[!g]=1 and ccsnoopaddr[!g]=latched address.
  - Drive ccinv[!g]=ccwrite[g] (write-intent miss).
  - Hold until cctrans[!g]=1. Then go to C2C0 if ccwrite[!g]=1, else RD0.
- C2C0/C2C1: snooper drives dWEN[!g]=1 with dstore[!g].
  - Controller writes dstore[!g] to RAM at line offset 0/4, and forwards it to dload.
  - When ramstate==ACCESS, drop dwait[g] and dwait[!g] to 0 in the same cycle.
  - ccwait[!g] stays 1 through C2C1.
- RD0/RD1: ramREN, ramaddr = line base | 0/4, dload=ramload.
  - dwait[g]=0 when ACCESS. RD1 returns to IDLE.
- IFETCH: ramREN, ramaddr=iaddr[g], iload=ramload.
  - iwait[g]=0 on ACCESS, then IDLE.
- The snooped core's own request is never granted while it is being snooped.
- At most one ccwait bit is ever 1.
- ramstate ERROR or BUSY is treated as not-ready. The same word is retried with no state advance.
- Defaults when not specified: waits 1, ccwait/ccinv 0, ram strobes 0, addresses/data 0.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE, rr 0.
  - dwait=iwait=2'b11, ccwait=ccinv=0, ccsnoopaddr* 0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, dload=iload=0.
- Reset mid-transaction aborts it. No strobe is asserted in the cycle after RST deasserts.
- Outputs are combinational from state and inputs. A RAM-ready word completes in the same cycle ramstate==ACCESS.
- Grant latency: a request seen in IDLE enters its first transaction state on the next edge.
- Minimum latencies with 1-cycle RAM:
  - icache fetch 2 cycles.
  - Writeback 3 cycles.
  - Clean miss: SNOOP(1 + response wait) + RD 2 + IDLE.
- Requests must be held stable until the corresponding wait drops. Dropping a request mid-transaction is illegal, and behaviour is undefined.

## Test plan
- icache0 and icache1 assert iREN together in IDLE after reset, 1-cycle RAM.
  - Required: iwait=2'b10 first, then 2'b01, each one cycle after grant.
  - rr ends at 0.
- dcache0 writeback dWEN[0]=1 at 0x100 with data 0xDEAD_BEEF / 0xCAFE_F00D, while iREN[1]=1.
  - Required: ramWEN addr 0x100 then 0x104 with those data; the icache is served only afterwards.
- dcache1 clean miss daddr1=0x204, ccwrite=0; core0 responds cctrans[0]=1, ccwrite[0]=0 after 3 cycles.
  - Required: ccwait=2'b01, ccsnoopaddr0=0x200, ccinv=0.
  - Then ramREN at 0x200 and 0x204, with dwait[1] pulsing low twice.
- dcache0 write-intent miss 0x40; core1 dirty with 0x11 / 0x22.
  - Required: ccinv[1]=1, ramWEN 0x40=0x11 and 0x44=0x22.
  - dload 0x11 then 0x22, with dwait=2'b00 in each ACCESS cycle.
- ramstate BUSY for 4 cycles during RD0.
  - Required: state holds, dwait stays 1, ramaddr unchanged; completes after ACCESS.
- RST pulsed during C2C1.
  - Required: all outputs take their reset values immediately; IDLE on release.
